seg7_bcd_display: RTL and testbench

//  Parametrised multi-digit 7-segment display driver for binary counters such as the bomb count.
//  - Converts a WIDTH-bit unsigned binary value to DIGITS decimal digits, sequentially (double-dabble, one bit per clock).
//  - Drives DIGITS active-low 7-segment digits, with optional leading-zero blanking, overflow indication and blinking.
//  - Sits between game/control logic and the board HEX displays.

---
 rtl/seg7_bcd_display_if.sv | 24 ++
 rtl/seg7_bcd_display.sv | 169 ++++++++++++++++
 tb/tb_seg7_bcd_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_display_if.sv
// Handshake and display bus between the control logic and the 7-segment
// display driver.
interface seg7_bcd_display_if #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
);
  logic [WIDTH-1:0]    valor_in;
  logic                cargar;
  logic                parpadeo_en;
  logic                listo;
  logic                hecho;
  logic                desbordado;
  logic [7*DIGITS-1:0] segs;

  modport master (
    output valor_in, cargar, parpadeo_en,
    input  listo, hecho, desbordado, segs
  );

  modport slave (
    input  valor_in, cargar, parpadeo_en,
    output listo, hecho, desbordado, segs
  );
endinterface

// File: rtl/seg7_bcd_display.sv
// Multi-digit active-low 7-segment driver: sequential double-dabble binary to
// BCD conversion, leading-zero blanking, overflow dashes and blinking.

module seg7_digit_enc (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module seg7_bcd_display #(
  parameter int WIDTH     = 6,
  parameter int DIGITS    = 2,
  parameter int BLANK_LZ  = 1,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_bcd_display_if.slave bus
);
  localparam int BW   = 4 * DIGITS;
  localparam int CW   = (WIDTH > BW) ? WIDTH : BW;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int BLW  = $clog2(BLINK_DIV);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAXV_I = pow10(DIGITS) - 1;
  localparam logic [CW-1:0] MAXV = CW'(MAXV_I);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    shift_q;
  logic [BW-1:0]       bcd_q;
  logic [CNTW-1:0]     cnt_q;
  logic                ovf_q;
  logic [7*DIGITS-1:0] disp_q;
  logic [7*DIGITS-1:0] segs_q;
  logic                listo_q;
  logic                hecho_q;
  logic                desb_q;
  logic [BLW-1:0]      blink_cnt;
  logic                phase_on;

  // Double-dabble step: correct nibbles >=5, then shift one bit in
  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] dd_next;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    dd_next = {bcd_adj, shift_q} << 1;
  end

  logic [DIGITS-1:0][6:0] dig_seg;
  seg7_digit_enc u_enc [DIGITS-1:0] (.nib(bcd_q), .seg(dig_seg));

  // Scan from the top digit down; upper_zero tracks "all digits above are 0"
  logic [DIGITS-1:0][6:0] new_disp;
  logic                   upper_zero;

  always_comb begin
    new_disp   = '1;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_q)
        new_disp[i] = DASH;
      else if (BLANK_LZ != 0 && i != 0 && upper_zero && bcd_q[4*i +: 4] == 4'd0)
        new_disp[i] = BLANK;
      else
        new_disp[i] = dig_seg[i];
      if (bcd_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  logic [7*DIGITS-1:0] disp_d;
  logic [BLW-1:0]      blink_d;
  logic                phase_d;

  always_comb begin
    disp_d = (state == UPDATE) ? new_disp : disp_q;
    if (!bus.parpadeo_en) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (blink_cnt == BLW'(BLINK_DIV - 1)) begin
      blink_d = '0;
      phase_d = ~phase_on;
    end else begin
      blink_d = blink_cnt + 1'b1;
      phase_d = phase_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      disp_q    <= '1;
      segs_q    <= '1;
      listo_q   <= 1'b1;
      hecho_q   <= 1'b0;
      desb_q    <= 1'b0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      hecho_q   <= 1'b0;
      blink_cnt <= blink_d;
      phase_on  <= phase_d;
      disp_q    <= disp_d;
      segs_q    <= phase_d ? disp_d : '1;
      case (state)
        IDLE: begin
          if (bus.cargar) begin
            shift_q <= bus.valor_in;
            bcd_q   <= '0;
            cnt_q   <= CNTW'(WIDTH);
            ovf_q   <= CW'(bus.valor_in) > MAXV;
            listo_q <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= dd_next[BW+WIDTH-1:WIDTH];
          shift_q <= dd_next[WIDTH-1:0];
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) state <= UPDATE;
        end
        UPDATE: begin
          desb_q  <= ovf_q;
          hecho_q <= 1'b1;
          listo_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.segs       = segs_q;
  assign bus.listo      = listo_q;
  assign bus.hecho      = hecho_q;
  assign bus.desbordado = desb_q;
endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed bench: three driver configurations (2 digits with and without
// leading-zero blanking, 1 digit) checked against hand-computed patterns.
module tb_seg7_bcd_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_bcd_display_if #(.WIDTH(6), .DIGITS(2)) if_main ();
  seg7_bcd_display_if #(.WIDTH(6), .DIGITS(2)) if_nolz ();
  seg7_bcd_display_if #(.WIDTH(6), .DIGITS(1)) if_one ();

  assign if_nolz.valor_in    = if_main.valor_in;
  assign if_nolz.cargar      = if_main.cargar;
  assign if_nolz.parpadeo_en = if_main.parpadeo_en;

  seg7_bcd_display #(.WIDTH(6), .DIGITS(2), .BLANK_LZ(1), .BLINK_DIV(4))
    u_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
  seg7_bcd_display #(.WIDTH(6), .DIGITS(2), .BLANK_LZ(0), .BLINK_DIV(4))
    u_nolz (.clk(clk), .rst_n(rst_n), .bus(if_nolz));
  seg7_bcd_display #(.WIDTH(6), .DIGITS(1), .BLANK_LZ(1), .BLINK_DIV(4))
    u_one (.clk(clk), .rst_n(rst_n), .bus(if_one));

  int checks = 0;
  int failures = 0;
  int hecho_cnt = 0;

  localparam logic [13:0] BLANK2 = 14'h3FFF;

  always @(negedge clk) if (if_main.hecho) hecho_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Load v; returns cycles from accepting edge to hecho (-1 on timeout).
  // Display must hold prev for the whole conversion.
  task automatic load_main(input logic [5:0] v, input logic [13:0] prev, output int lat);
    lat = -1;
    @(negedge clk); if_main.valor_in = v; if_main.cargar = 1'b1;
    @(negedge clk); if_main.cargar = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 6) chk("hold_during_conv", 32'(if_main.segs), 32'(prev));
      if (if_main.hecho) begin lat = k; break; end
    end
  endtask

  task automatic load_one(input logic [5:0] v, output int lat);
    lat = -1;
    @(negedge clk); if_one.valor_in = v; if_one.cargar = 1'b1;
    @(negedge clk); if_one.cargar = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if_one.hecho) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat;
    int hc0;
    int found;
    logic [13:0] d37;
    logic [13:0] exp;
    d37 = {7'h30, 7'h78};
    if_main.valor_in = '0; if_main.cargar = 1'b0; if_main.parpadeo_en = 1'b0;
    if_one.valor_in = '0;  if_one.cargar = 1'b0;  if_one.parpadeo_en = 1'b0;

    // 1: reset state
    #12;
    chk("rst_segs", 32'(if_main.segs), 32'(BLANK2));
    chk("rst_listo", 32'(if_main.listo), 1);
    chk("rst_hecho", 32'(if_main.hecho), 0);
    chk("rst_desb", 32'(if_main.desbordado), 0);
    chk("rst_one_segs", 32'(if_one.segs), 32'h7F);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_segs", 32'(if_main.segs), 32'(BLANK2));
    chk("idle_listo", 32'(if_main.listo), 1);

    // 2: load 37, latency and pulse width
    load_main(6'd37, BLANK2, lat);
    chk("lat37", 32'(lat), 7);
    chk("seg37", 32'(if_main.segs), 32'(d37));
    chk("nolz37", 32'(if_nolz.segs), 32'(d37));
    @(negedge clk);
    chk("hecho_one_cycle", 32'(if_main.hecho), 0);
    chk("listo_after", 32'(if_main.listo), 1);

    // 3: leading-zero blanking
    load_main(6'd5, d37, lat);
    chk("lat5", 32'(lat), 7);
    chk("seg5", 32'(if_main.segs), 32'({7'h7F, 7'h12}));
    chk("nolz5", 32'(if_nolz.segs), 32'({7'h40, 7'h12}));
    load_main(6'd0, {7'h7F, 7'h12}, lat);
    chk("seg0", 32'(if_main.segs), 32'({7'h7F, 7'h40}));
    chk("nolz0", 32'(if_nolz.segs), 32'({7'h40, 7'h40}));
    chk("desb0", 32'(if_main.desbordado), 0);
    load_main(6'd63, {7'h7F, 7'h40}, lat);
    chk("seg63", 32'(if_main.segs), 32'({7'h02, 7'h30}));

    // 4: single digit overflow
    load_one(6'd12, lat);
    chk("one_lat", 32'(lat), 7);
    chk("one_ovf_seg", 32'(if_one.segs), 32'h3F);
    chk("one_ovf_desb", 32'(if_one.desbordado), 1);
    load_one(6'd9, lat);
    chk("one9_seg", 32'(if_one.segs), 32'h10);
    chk("one9_desb", 32'(if_one.desbordado), 0);

    // 5: cargar while busy is dropped
    hc0 = hecho_cnt;
    @(negedge clk); if_main.valor_in = 6'd21; if_main.cargar = 1'b1;
    @(negedge clk); if_main.cargar = 1'b0;
    @(negedge clk); if_main.valor_in = 6'd63; if_main.cargar = 1'b1;
    @(negedge clk); if_main.cargar = 1'b0;
    repeat (15) @(negedge clk);
    chk("seg21", 32'(if_main.segs), 32'({7'h24, 7'h79}));
    chk("hecho_once", 32'(hecho_cnt - hc0), 1);
    chk("listo21", 32'(if_main.listo), 1);

    // reset mid-conversion of 44
    hc0 = hecho_cnt;
    @(negedge clk); if_main.valor_in = 6'd44; if_main.cargar = 1'b1;
    @(negedge clk); if_main.cargar = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_segs", 32'(if_main.segs), 32'(BLANK2));
    chk("abort_listo", 32'(if_main.listo), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_hecho", 32'(hecho_cnt - hc0), 0);
    chk("abort_blank", 32'(if_main.segs), 32'(BLANK2));

    // 6: blink
    load_main(6'd37, BLANK2, lat);
    chk("seg37b", 32'(if_main.segs), 32'(d37));
    @(negedge clk); if_main.parpadeo_en = 1'b1;
    found = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (if_main.segs == BLANK2) begin found = k; break; end
    end
    chk("blink_first_off", 32'(found), 4);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp = (j < 4 || j == 8) ? BLANK2 : d37;
      chk($sformatf("blink_%0d", j), 32'(if_main.segs), 32'(exp));
    end
    chk("blink_listo", 32'(if_main.listo), 1);
    if_main.parpadeo_en = 1'b0;
    @(negedge clk);
    chk("blink_off_steady", 32'(if_main.segs), 32'(d37));
    repeat (5) @(negedge clk);
    chk("steady_later", 32'(if_main.segs), 32'(d37));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
